modbus_req_decoder: RTL and testbench
=====================================

Name: modbus_req_decoder

Overview:
- Downstream consumer of the UART RX frame receiver in the Modbus RTU slave.
- Takes the receiver's byte stream, end-of-frame indication and CRC verdict, then buffers and parses one request frame.
- Validates a frame for function 03h, 06h or 10h, executes holding-register writes through a simple write port, and hands a request/exception descriptor to the response builder.

Parameters:
- SLAVE_ID, 8'h01, own Modbus address; 8'h00 is accepted as broadcast.
- REG_NUM, 16, number of implemented holding registers (addresses 0..REG_NUM-1).
- BUF_WIDTH, 8, frame buffer address width; buffer holds 2**BUF_WIDTH bytes.

Ports:
- clk  in  1  system clock, all logic on posedge.
- rst  in  1  asynchronous reset, active-low.
- iAction  in  1  high while the receiver is inside a frame.
- iData  in  8  received byte, valid while iDataReady is high.
- iDataReady  in  1  byte strobe; rising edge = one new byte.
- iCrcErr  in  1  frame CRC error, valid from 1 clk after iAction falls.
- oRegWe  out  1  one-clk register write strobe.
- oRegAddr  out  16  write address.
- oRegData  out  16  write data.
- oReqValid  out  1  descriptor valid, held until acknowledged.
- iReqAck  in  1  response builder accepts the descriptor.
- oReqFunc  out  8  function code (03h/06h/10h, or func|80h on exception).
- oReqStart  out  16  start or register address.
- oReqQty  out  16  quantity; for 06h, the written value.
- oReqExc  out  8  exception code; 0 = none.

Behaviour:
- Reset (rst=0, async): every output is 0, state IDLE, byte index 0, overflow flag clear.
- Edge detection: iAction and iDataReady are registered once; rising/falling edges come from the registered copy.
- States: IDLE, RECV, CRCWAIT, CHECK, WRITE, REPORT.
- IDLE: a rising edge on iAction goes to RECV; byte index cleared, overflow cleared.
- RECV: each iDataReady rising edge stores iData at buf[idx] and increments idx.
  - Bytes 0..6 are also captured into the header registers: addr, func, f1hi, f1lo, f2hi, f2lo, bytecount.
  - idx reaching 2**BUF_WIDTH sets overflow; further bytes are dropped.
  - A falling edge on iAction goes to CRCWAIT.
- CRCWAIT (1 clk): samples iCrcErr, then goes to CHECK.
- CHECK (1 clk) applies these rules in order:
  1. Silent discard (to IDLE, no outputs) if any of: CRC error; overflow; idx<4; addr not SLAVE_ID and not 0.
  2. Function not 03h/06h/10h: exception 01h.
  3. Length check: for 03h and 06h, idx must equal 8; for 10h, idx must equal 9+bytecount; otherwise silent discard.
  4. Function 03h (start=f1, qty=f2): qty=0 or qty>125 gives exception 03h; start+qty>REG_NUM (17-bit compare) gives exception 02h.
  5. Function 06h (addr=f1, value=f2): addr>=REG_NUM gives exception 02h.
  6. Function 10h: qty=0, qty>123 or bytecount != 2*qty gives exception 03h; start+qty>REG_NUM gives exception 02h.
  7. Broadcast with function 03h, or broadcast with any exception: silent discard.
  8. A valid 06h or 10h goes to WRITE; a valid 03h or any exception goes to REPORT.
- WRITE:
  - One oRegWe pulse per register on consecutive clocks; first pulse is the clock after CHECK.
  - 06h: one write, oRegAddr=f1, oRegData=f2.
  - 10h: write k (0..qty-1) uses oRegAddr=start+k and oRegData={buf[7+2k], buf[8+2k]} (big-endian).
  - After the last write: broadcast goes to IDLE, otherwise to REPORT.
  - oRegAddr and oRegData hold their last value when oRegWe=0.
- REPORT:
  - oReqValid=1 with oReqFunc, oReqStart, oReqQty and oReqExc stable.
  - On the first clk with iReqAck=1: oReqValid goes to 0 on the next clk, state to IDLE.
  - On an exception, oReqFunc=func|80h and oReqStart/oReqQty=0.
- Frames that start while in CRCWAIT, CHECK, WRITE or REPORT are ignored entirely: no buffering, and no re-arm until IDLE sees a fresh rising edge of iAction.
- Reset asserted mid-WRITE aborts the remaining writes immediately.
- Latency: the first oRegWe, or oReqValid when there are no writes, occurs 3 clks after the clock that registers iAction low.

Test Plan:
- Frame 01 06 00 03 12 34 + good CRC -> a single oRegWe with oRegAddr=0003h, oRegData=1234h; then oReqValid with func 06h, start 0003h, qty 1234h, exc 00h.
- Frame 01 10 00 02 00 02 04 AA BB CC DD + CRC -> writes (0002h, AABBh) then (0003h, CCDDh) on consecutive clocks; descriptor func 10h, start 2, qty 2.
- Frame 01 03 00 0E 00 04 + CRC with REG_NUM=16 -> no writes; descriptor func 83h, exc 02h.
- Same 06h frame but iCrcErr=1 -> no oRegWe, no oReqValid, back in IDLE.
- Frame addressed to 05h, then broadcast 00 06 00 01 00 07 -> first frame ignored; broadcast gives a write (0001h, 0007h) and no oReqValid.
- Function 04h frame -> descriptor func 84h, exc 01h. Hold iReqAck=0 for 10 clks -> oReqValid stays high; pulse iReqAck -> oReqValid low next clk. Assert rst during a 10h WRITE -> oRegWe=0 and oReqValid=0 immediately.

Source files
------------

// File: rtl/modbus_req_decoder.sv
`default_nettype none
// ============================================================================
// Module   : modbus_req_decoder
// Purpose  : Buffers one Modbus RTU request frame from the UART RX frame
//            receiver, validates it (address, length, function 03h/06h/10h,
//            register range), performs holding-register writes through a
//            simple write port and presents a request/exception descriptor
//            to the response builder.
// Ports    : clk          system clock, all logic on posedge
//            rst          asynchronous reset, active-low
//            iAction      high while the receiver is inside a frame
//            iData        received byte, valid while iDataReady is high
//            iDataReady   byte strobe, rising edge = one new byte
//            iCrcErr      frame CRC error, valid 1 clk after iAction falls
//            oRegWe       one-clk register write strobe
//            oRegAddr     write address (holds when oRegWe=0)
//            oRegData     write data    (holds when oRegWe=0)
//            oReqValid    descriptor valid, held until iReqAck
//            iReqAck      response builder accepts the descriptor
//            oReqFunc     function code, or func|80h on exception
//            oReqStart    start / register address (0 on exception)
//            oReqQty      quantity, or written value for 06h (0 on exception)
//            oReqExc      exception code, 0 = none
// Revision : 1.0 - initial release
// ============================================================================
module modbus_req_decoder #(
    parameter logic [7:0] SLAVE_ID  = 8'h01,
    parameter int         REG_NUM   = 16,
    parameter int         BUF_WIDTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        iAction,
    input  logic [7:0]  iData,
    input  logic        iDataReady,
    input  logic        iCrcErr,
    output logic        oRegWe,
    output logic [15:0] oRegAddr,
    output logic [15:0] oRegData,
    output logic        oReqValid,
    input  logic        iReqAck,
    output logic [7:0]  oReqFunc,
    output logic [15:0] oReqStart,
    output logic [15:0] oReqQty,
    output logic [7:0]  oReqExc
);

    localparam int c_DEPTH = 2 ** BUF_WIDTH;
    localparam int c_IDX_W = BUF_WIDTH + 1;

    localparam logic [2:0] c_S_IDLE    = 3'd0;
    localparam logic [2:0] c_S_RECV    = 3'd1;
    localparam logic [2:0] c_S_CRCWAIT = 3'd2;
    localparam logic [2:0] c_S_CHECK   = 3'd3;
    localparam logic [2:0] c_S_WRITE   = 3'd4;
    localparam logic [2:0] c_S_REPORT  = 3'd5;

    localparam logic [7:0] c_FC_READ  = 8'h03;
    localparam logic [7:0] c_FC_WR1   = 8'h06;
    localparam logic [7:0] c_FC_WRN   = 8'h10;

    // ------------------------------------------------------------------------
    // Input registering and edge detection
    // ------------------------------------------------------------------------
    logic       r_action, r_action_d;
    logic       r_dr, r_dr_d;
    logic [7:0] r_data;
    logic       w_action_rise, w_action_fall, w_byte_stb;

    assign w_action_rise = r_action & ~r_action_d;
    assign w_action_fall = ~r_action & r_action_d;
    assign w_byte_stb    = r_dr & ~r_dr_d;

    // ------------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------------
    logic [2:0]           r_state, w_state_nxt;
    logic [c_IDX_W-1:0]   r_idx;
    logic                 r_ovf;
    logic [7:0]           r_hdr_addr, r_hdr_func, r_bcnt;
    logic [15:0]          r_f1, r_f2;
    logic                 r_crc_err;
    logic [7:0]           r_wr_k, r_wr_qty;
    logic [BUF_WIDTH-1:0] r_rd_ptr;
    logic [7:0]           r_buf [0:c_DEPTH-1];
    logic [15:0]          r_reg_addr, r_reg_data;
    logic [7:0]           r_req_func, r_req_exc;
    logic [15:0]          r_req_start, r_req_qty;

    logic                 w_store;
    logic [BUF_WIDTH-1:0] w_rd_ptr1;

    // Bytes are accepted only while receiving and until the buffer fills.
    assign w_store   = (r_state == c_S_RECV) && w_byte_stb && !r_ovf;
    assign w_rd_ptr1 = r_rd_ptr + BUF_WIDTH'(1);

    // ------------------------------------------------------------------------
    // Frame validation (evaluated while in CHECK)
    // ------------------------------------------------------------------------
    logic        w_bcast, w_func_ok, w_len_ok, w_discard;
    logic [7:0]  w_exc;
    logic [16:0] w_end;

    assign w_bcast   = (r_hdr_addr == 8'h00);
    assign w_func_ok = (r_hdr_func == c_FC_READ) || (r_hdr_func == c_FC_WR1) ||
                       (r_hdr_func == c_FC_WRN);
    // Frame length includes the two CRC bytes.
    assign w_len_ok  = (r_hdr_func == c_FC_WRN) ?
                       (17'(r_idx) == (17'(r_bcnt) + 17'd9)) :
                       (r_idx == c_IDX_W'(8));
    // 17-bit sum so start+qty cannot wrap before the range compare.
    assign w_end     = 17'(r_f1) + 17'(r_f2);

    always_comb begin
        w_discard = 1'b0;
        w_exc     = 8'h00;
        if (r_crc_err || r_ovf || (r_idx < c_IDX_W'(4)) ||
            ((r_hdr_addr != SLAVE_ID) && !w_bcast)) begin
            w_discard = 1'b1;
        end else if (!w_func_ok) begin
            w_exc = 8'h01;
        end else if (!w_len_ok) begin
            w_discard = 1'b1;
        end else if (r_hdr_func == c_FC_READ) begin
            if ((r_f2 == 16'd0) || (r_f2 > 16'd125)) begin
                w_exc = 8'h03;
            end else if (w_end > 17'(REG_NUM)) begin
                w_exc = 8'h02;
            end
        end else if (r_hdr_func == c_FC_WR1) begin
            if ({1'b0, r_f1} >= 17'(REG_NUM)) begin
                w_exc = 8'h02;
            end
        end else begin
            if ((r_f2 == 16'd0) || (r_f2 > 16'd123) ||
                (17'(r_bcnt) != {r_f2, 1'b0})) begin
                w_exc = 8'h03;
            end else if (w_end > 17'(REG_NUM)) begin
                w_exc = 8'h02;
            end
        end
        // A broadcast never gets a response, so reads and errors are dropped.
        if (!w_discard && w_bcast &&
            ((w_exc != 8'h00) || (r_hdr_func == c_FC_READ))) begin
            w_discard = 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= c_S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_S_IDLE:    if (w_action_rise) w_state_nxt = c_S_RECV;
            c_S_RECV:    if (w_action_fall) w_state_nxt = c_S_CRCWAIT;
            c_S_CRCWAIT: w_state_nxt = c_S_CHECK;
            c_S_CHECK: begin
                if (w_discard) begin
                    w_state_nxt = c_S_IDLE;
                end else if ((w_exc == 8'h00) && (r_hdr_func != c_FC_READ)) begin
                    w_state_nxt = c_S_WRITE;
                end else begin
                    w_state_nxt = c_S_REPORT;
                end
            end
            c_S_WRITE: begin
                if (r_wr_k == (r_wr_qty - 8'd1)) begin
                    w_state_nxt = w_bcast ? c_S_IDLE : c_S_REPORT;
                end
            end
            c_S_REPORT:  if (iReqAck) w_state_nxt = c_S_IDLE;
            default:     w_state_nxt = c_S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------------
    always_comb begin
        oRegWe    = (r_state == c_S_WRITE);
        oReqValid = (r_state == c_S_REPORT);
    end

    assign oRegAddr  = r_reg_addr;
    assign oRegData  = r_reg_data;
    assign oReqFunc  = r_req_func;
    assign oReqStart = r_req_start;
    assign oReqQty   = r_req_qty;
    assign oReqExc   = r_req_exc;

    // ------------------------------------------------------------------------
    // Frame buffer storage (no reset needed, contents are qualified by r_idx)
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_store) begin
            r_buf[r_idx[BUF_WIDTH-1:0]] <= r_data;
        end
    end

    // ------------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_action    <= 1'b0;
            r_action_d  <= 1'b0;
            r_dr        <= 1'b0;
            r_dr_d      <= 1'b0;
            r_data      <= 8'h00;
            r_idx       <= '0;
            r_ovf       <= 1'b0;
            r_hdr_addr  <= 8'h00;
            r_hdr_func  <= 8'h00;
            r_bcnt      <= 8'h00;
            r_f1        <= 16'h0000;
            r_f2        <= 16'h0000;
            r_crc_err   <= 1'b0;
            r_wr_k      <= 8'h00;
            r_wr_qty    <= 8'h00;
            r_rd_ptr    <= '0;
            r_reg_addr  <= 16'h0000;
            r_reg_data  <= 16'h0000;
            r_req_func  <= 8'h00;
            r_req_start <= 16'h0000;
            r_req_qty   <= 16'h0000;
            r_req_exc   <= 8'h00;
        end else begin
            r_action   <= iAction;
            r_action_d <= r_action;
            r_dr       <= iDataReady;
            r_dr_d     <= r_dr;
            r_data     <= iData;

            if ((r_state == c_S_IDLE) && w_action_rise) begin
                r_idx <= '0;
                r_ovf <= 1'b0;
            end

            if (w_store) begin
                r_idx <= r_idx + c_IDX_W'(1);
                if (r_idx == c_IDX_W'(c_DEPTH - 1)) begin
                    r_ovf <= 1'b1;
                end
                if (r_idx < c_IDX_W'(7)) begin
                    case (r_idx[2:0])
                        3'd0:    r_hdr_addr <= r_data;
                        3'd1:    r_hdr_func <= r_data;
                        3'd2:    r_f1[15:8] <= r_data;
                        3'd3:    r_f1[7:0]  <= r_data;
                        3'd4:    r_f2[15:8] <= r_data;
                        3'd5:    r_f2[7:0]  <= r_data;
                        default: r_bcnt     <= r_data;
                    endcase
                end
            end

            if (r_state == c_S_CRCWAIT) begin
                r_crc_err <= iCrcErr;
            end

            if (r_state == c_S_CHECK) begin
                // Broadcasts never report, so the descriptor is left untouched.
                if (!w_discard && !w_bcast) begin
                    r_req_exc <= w_exc;
                    if (w_exc != 8'h00) begin
                        r_req_func  <= r_hdr_func | 8'h80;
                        r_req_start <= 16'h0000;
                        r_req_qty   <= 16'h0000;
                    end else begin
                        r_req_func  <= r_hdr_func;
                        r_req_start <= r_f1;
                        r_req_qty   <= r_f2;
                    end
                end
                // Preload the first write so it appears with the first strobe.
                if (w_state_nxt == c_S_WRITE) begin
                    r_wr_k     <= 8'h00;
                    r_reg_addr <= r_f1;
                    r_rd_ptr   <= BUF_WIDTH'(9);
                    if (r_hdr_func == c_FC_WR1) begin
                        r_wr_qty   <= 8'd1;
                        r_reg_data <= r_f2;
                    end else begin
                        r_wr_qty   <= r_f2[7:0];
                        r_reg_data <= {r_buf[7], r_buf[8]};
                    end
                end
            end

            // Advance to the next register while more writes remain.
            if ((r_state == c_S_WRITE) && (w_state_nxt == c_S_WRITE)) begin
                r_wr_k     <= r_wr_k + 8'd1;
                r_reg_addr <= r_reg_addr + 16'd1;
                r_reg_data <= {r_buf[r_rd_ptr], r_buf[w_rd_ptr1]};
                r_rd_ptr   <= r_rd_ptr + BUF_WIDTH'(2);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_modbus_req_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_modbus_req_decoder
// Purpose  : Directed self-checking bench for modbus_req_decoder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_modbus_req_decoder;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        iAction = 1'b0;
    logic [7:0]  iData = 8'h00;
    logic        iDataReady = 1'b0;
    logic        iCrcErr = 1'b0;
    logic        iReqAck = 1'b0;
    logic        oRegWe, oReqValid;
    logic [15:0] oRegAddr, oRegData, oReqStart, oReqQty;
    logic [7:0]  oReqFunc, oReqExc;

    always #5 clk = ~clk;

    modbus_req_decoder #(
        .SLAVE_ID (8'h01),
        .REG_NUM  (16),
        .BUF_WIDTH(8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .iAction   (iAction),
        .iData     (iData),
        .iDataReady(iDataReady),
        .iCrcErr   (iCrcErr),
        .oRegWe    (oRegWe),
        .oRegAddr  (oRegAddr),
        .oRegData  (oRegData),
        .oReqValid (oReqValid),
        .iReqAck   (iReqAck),
        .oReqFunc  (oReqFunc),
        .oReqStart (oReqStart),
        .oReqQty   (oReqQty),
        .oReqExc   (oReqExc)
    );

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  fb [0:15];
    int          fn;
    logic [15:0] wr_addr [0:7];
    logic [15:0] wr_data [0:7];
    int          wr_cyc  [0:7];
    int          wr_n;
    int          vld_cyc;

    // Load n bytes, first byte in the most significant position of the low n bytes.
    task automatic load_frame(input logic [127:0] v, input int n);
        for (int i = 0; i < n; i++) fb[i] = v[8*(n-1-i) +: 8];
        fn = n;
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk); iData = b; iDataReady = 1'b1;
        repeat (2) @(negedge clk);
        iDataReady = 1'b0;
        @(negedge clk);
    endtask

    // Sends the frame and drops iAction on a negedge (cycle 0 of collection).
    task automatic drive_frame(input logic crc);
        @(negedge clk); iAction = 1'b1;
        repeat (2) @(negedge clk);
        for (int i = 0; i < fn; i++) send_byte(fb[i]);
        @(negedge clk); iAction = 1'b0; iCrcErr = crc;
    endtask

    // Records writes and the first oReqValid cycle, counted in negedges.
    task automatic collect();
        wr_n = 0; vld_cyc = 0;
        for (int c = 1; c <= 30 && vld_cyc == 0; c++) begin
            @(negedge clk);
            if (oRegWe) begin
                if (wr_n < 8) begin
                    wr_addr[wr_n] = oRegAddr; wr_data[wr_n] = oRegData; wr_cyc[wr_n] = c;
                end
                wr_n++;
            end
            if (oReqValid) vld_cyc = c;
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if ({oRegWe, oReqValid} !== 2'b00) begin errors++; $display("FAIL reset_strobes: got %b expected 00", {oRegWe, oReqValid}); end
        checks++; if ({oRegAddr, oRegData} !== 32'h0) begin errors++; $display("FAIL reset_wport: got %h expected 0", {oRegAddr, oRegData}); end
        checks++; if ({oReqFunc, oReqStart, oReqQty, oReqExc} !== 48'h0) begin errors++; $display("FAIL reset_desc: got %h expected 0", {oReqFunc, oReqStart, oReqQty, oReqExc}); end
        rst = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_write_single();
        load_frame({8'h01, 8'h06, 8'h00, 8'h03, 8'h12, 8'h34, 8'h5A, 8'hA5}, 8);
        drive_frame(1'b0); collect();
        checks++; if (wr_n !== 1) begin errors++; $display("FAIL w06_count: got %0d expected 1", wr_n); end
        checks++; if (wr_n >= 1 && {wr_addr[0], wr_data[0]} !== {16'h0003, 16'h1234}) begin errors++; $display("FAIL w06_write: got %h expected 00031234", {wr_addr[0], wr_data[0]}); end
        checks++; if (wr_n >= 1 && wr_cyc[0] !== 4) begin errors++; $display("FAIL w06_latency: got %0d expected 4", wr_cyc[0]); end
        checks++; if (vld_cyc !== 5) begin errors++; $display("FAIL w06_valid_cyc: got %0d expected 5", vld_cyc); end
        checks++; if ({oReqFunc, oReqStart, oReqQty, oReqExc} !== {8'h06, 16'h0003, 16'h1234, 8'h00}) begin errors++; $display("FAIL w06_desc: got %h expected 06000312 3400", {oReqFunc, oReqStart, oReqQty, oReqExc}); end
        checks++; if ({oRegWe, oRegAddr, oRegData} !== {1'b0, 16'h0003, 16'h1234}) begin errors++; $display("FAIL w06_hold: got %h expected 000031234", {oRegWe, oRegAddr, oRegData}); end
        @(negedge clk); iReqAck = 1'b1;
        @(negedge clk); iReqAck = 1'b0;
        checks++; if (oReqValid !== 1'b0) begin errors++; $display("FAIL w06_ack: got %b expected 0", oReqValid); end
    endtask

    task automatic test_write_multi();
        load_frame({8'h01, 8'h10, 8'h00, 8'h02, 8'h00, 8'h02, 8'h04, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11, 8'h22}, 13);
        drive_frame(1'b0); collect();
        checks++; if (wr_n !== 2) begin errors++; $display("FAIL w10_count: got %0d expected 2", wr_n); end
        checks++; if (wr_n >= 2 && {wr_addr[0], wr_data[0], wr_addr[1], wr_data[1]} !== {16'h0002, 16'hAABB, 16'h0003, 16'hCCDD}) begin errors++; $display("FAIL w10_writes: got %h %h %h %h expected 0002 AABB 0003 CCDD", wr_addr[0], wr_data[0], wr_addr[1], wr_data[1]); end
        checks++; if (wr_n >= 2 && {wr_cyc[0], wr_cyc[1]} !== {32'd4, 32'd5}) begin errors++; $display("FAIL w10_cycles: got %0d %0d expected 4 5", wr_cyc[0], wr_cyc[1]); end
        checks++; if (vld_cyc !== 6) begin errors++; $display("FAIL w10_valid_cyc: got %0d expected 6", vld_cyc); end
        checks++; if ({oReqFunc, oReqStart, oReqQty, oReqExc} !== {8'h10, 16'h0002, 16'h0002, 8'h00}) begin errors++; $display("FAIL w10_desc: got %h expected 10000200 0200", {oReqFunc, oReqStart, oReqQty, oReqExc}); end
        @(negedge clk); iReqAck = 1'b1;
        @(negedge clk); iReqAck = 1'b0;
        checks++; if (oReqValid !== 1'b0) begin errors++; $display("FAIL w10_ack: got %b expected 0", oReqValid); end
    endtask

    // One frame expecting a descriptor with no writes, then acknowledge it.
    task automatic test_report(input logic [63:0] frm, input logic [47:0] exp_desc, input int exp_cyc);
        load_frame(128'(frm), 8);
        drive_frame(1'b0); collect();
        checks++; if (wr_n !== 0) begin errors++; $display("FAIL rpt_nowrite f%h: got %0d expected 0", frm[55:48], wr_n); end
        checks++; if (vld_cyc !== exp_cyc) begin errors++; $display("FAIL rpt_valid_cyc f%h: got %0d expected %0d", frm[55:48], vld_cyc, exp_cyc); end
        checks++; if ({oReqFunc, oReqStart, oReqQty, oReqExc} !== exp_desc) begin errors++; $display("FAIL rpt_desc f%h: got %h expected %h", frm[55:48], {oReqFunc, oReqStart, oReqQty, oReqExc}, exp_desc); end
        @(negedge clk); iReqAck = 1'b1;
        @(negedge clk); iReqAck = 1'b0;
    endtask

    // One frame expecting no write and no descriptor.
    task automatic test_silent(input logic [63:0] frm, input int n, input logic crc);
        load_frame(128'(frm), n);
        drive_frame(crc); collect();
        checks++; if ({wr_n, vld_cyc} !== {32'd0, 32'd0}) begin errors++; $display("FAIL silent n%0d crc%b: got writes %0d valid %0d expected 0 0", n, crc, wr_n, vld_cyc); end
    endtask

    task automatic test_broadcast();
        test_silent({8'h05, 8'h06, 8'h00, 8'h01, 8'h00, 8'h07, 8'h5A, 8'hA5}, 8, 1'b0);
        load_frame({8'h00, 8'h06, 8'h00, 8'h01, 8'h00, 8'h07, 8'h5A, 8'hA5}, 8);
        drive_frame(1'b0); collect();
        checks++; if (wr_n !== 1) begin errors++; $display("FAIL bc_count: got %0d expected 1", wr_n); end
        checks++; if (wr_n >= 1 && {wr_addr[0], wr_data[0], wr_cyc[0]} !== {16'h0001, 16'h0007, 32'd4}) begin errors++; $display("FAIL bc_write: got %h %h %0d expected 0001 0007 4", wr_addr[0], wr_data[0], wr_cyc[0]); end
        checks++; if (vld_cyc !== 0) begin errors++; $display("FAIL bc_novalid: got %0d expected 0", vld_cyc); end
    endtask

    task automatic test_ack_hold();
        load_frame({8'h01, 8'h04, 8'h00, 8'h00, 8'h00, 8'h01, 8'h5A, 8'hA5}, 8);
        drive_frame(1'b0); collect();
        checks++; if ({oReqFunc, oReqStart, oReqQty, oReqExc} !== {8'h84, 32'h0, 8'h01}) begin errors++; $display("FAIL f04_desc: got %h expected 8400000000 01", {oReqFunc, oReqStart, oReqQty, oReqExc}); end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++; if ({oReqValid, oReqFunc, oReqExc} !== {1'b1, 8'h84, 8'h01}) begin errors++; $display("FAIL hold_%0d: got %h expected 18401", i, {oReqValid, oReqFunc, oReqExc}); end
        end
        iReqAck = 1'b1;
        @(negedge clk); iReqAck = 1'b0;
        checks++; if (oReqValid !== 1'b0) begin errors++; $display("FAIL hold_ack: got %b expected 0", oReqValid); end
    endtask

    task automatic test_reset_mid_write();
        bit seen = 1'b0;
        load_frame({8'h01, 8'h10, 8'h00, 8'h05, 8'h00, 8'h03, 8'h06, 8'h11, 8'h11, 8'h22, 8'h22, 8'h33, 8'h33, 8'h11, 8'h22}, 15);
        drive_frame(1'b0);
        for (int c = 0; c < 30 && !seen; c++) begin
            @(negedge clk);
            if (oRegWe) seen = 1'b1;
        end
        checks++; if (!seen) begin errors++; $display("FAIL mid_first_write: got none expected oRegWe within 30 clks"); end
        checks++; if (oRegAddr !== 16'h0005) begin errors++; $display("FAIL mid_first_addr: got %h expected 0005", oRegAddr); end
        rst = 1'b0;
        #1;
        checks++; if ({oRegWe, oReqValid, oRegAddr, oRegData} !== 34'h0) begin errors++; $display("FAIL mid_reset_now: got %h expected 0", {oRegWe, oReqValid, oRegAddr, oRegData}); end
        repeat (2) @(negedge clk);
        checks++; if ({oRegWe, oReqValid} !== 2'b00) begin errors++; $display("FAIL mid_reset_hold: got %b expected 00", {oRegWe, oReqValid}); end
        rst = 1'b1;
        repeat (8) @(negedge clk);
        checks++; if ({oRegWe, oReqValid} !== 2'b00) begin errors++; $display("FAIL mid_after: got %b expected 00", {oRegWe, oReqValid}); end
    endtask

    initial begin
        test_reset();
        test_write_single();
        test_write_multi();
        // Range errors and boundaries
        test_report({8'h01, 8'h03, 8'h00, 8'h0E, 8'h00, 8'h04, 8'h5A, 8'hA5}, {8'h83, 32'h0, 8'h02}, 4);
        test_report({8'h01, 8'h03, 8'h00, 8'h00, 8'h00, 8'h10, 8'h5A, 8'hA5}, {8'h03, 16'h0000, 16'h0010, 8'h00}, 4);
        test_report({8'h01, 8'h03, 8'h00, 8'h00, 8'h00, 8'h7E, 8'h5A, 8'hA5}, {8'h83, 32'h0, 8'h03}, 4);
        test_report({8'h01, 8'h06, 8'h00, 8'h10, 8'h00, 8'h01, 8'h5A, 8'hA5}, {8'h86, 32'h0, 8'h02}, 4);
        // CRC error and short frame
        test_silent({8'h01, 8'h06, 8'h00, 8'h03, 8'h12, 8'h34, 8'h5A, 8'hA5}, 8, 1'b1);
        test_silent({8'h00, 8'h01, 8'h06, 8'h00, 8'h03, 8'h12, 8'h34, 8'h5A}, 7, 1'b0);
        test_broadcast();
        test_ack_hold();
        test_reset_mid_write();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
